// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with an optional even-parity bit and
// a forced idle gap after each frame. x is always driven from a flop.
module bit_serializer #(
  parameter int WIDTH  = 8,
  parameter int GAP    = 2,
  parameter int PARITY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             x,
  output logic             busy,
  output logic             frame_done
);

  localparam int L  = WIDTH + ((PARITY != 0) ? 1 : 0);
  localparam int CW = $clog2(L + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [CW-1:0] L_C = CW'(L);
  localparam logic [CW-1:0] W_C = CW'(WIDTH);
  localparam logic [GW-1:0] G_C = GW'(GAP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_sr, w_sr_next;
  logic             r_par, w_par_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [GW-1:0]    r_gcnt, w_gcnt_next;
  logic             r_x, w_x_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_par   <= 1'b0;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_x     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sr    <= w_sr_next;
      r_par   <= w_par_next;
      r_cnt   <= w_cnt_next;
      r_gcnt  <= w_gcnt_next;
      r_x     <= w_x_next;
    end
  end

  // r_cnt holds the 1-based index of the bit currently on x.
  always_comb begin
    w_state_next = r_state;
    w_sr_next    = r_sr;
    w_par_next   = r_par;
    w_cnt_next   = r_cnt;
    w_gcnt_next  = r_gcnt;
    w_x_next     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_in) begin
          w_state_next = S_SHIFT;
          w_sr_next    = data_in;
          w_par_next   = ^data_in;
          w_cnt_next   = CW'(1);
          w_x_next     = data_in[WIDTH-1];
        end
      end
      S_SHIFT: begin
        if (r_cnt >= L_C) begin
          w_cnt_next = '0;
          w_sr_next  = '0;
          w_par_next = 1'b0;
          if (GAP > 0) begin
            w_state_next = S_GAP;
            w_gcnt_next  = GW'(1);
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
          w_sr_next  = r_sr << 1;
          // Past the last data bit only the parity bit remains.
          w_x_next   = (r_cnt < W_C) ? w_sr_next[WIDTH-1] : r_par;
        end
      end
      S_GAP: begin
        if (r_gcnt >= G_C) begin
          w_state_next = S_IDLE;
          w_gcnt_next  = '0;
        end else begin
          w_gcnt_next = r_gcnt + GW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_sr_next    = '0;
        w_par_next   = 1'b0;
        w_cnt_next   = '0;
        w_gcnt_next  = '0;
      end
    endcase
  end

  assign x          = r_x;
  assign busy       = (r_state == S_SHIFT) || (r_state == S_GAP);
  assign frame_done = (r_state == S_SHIFT) && (r_cnt == L_C);
  assign ready_out  = (r_state == S_IDLE) && !reset;

endmodule

// File: tb/tb_bit_serializer.sv
// Drives two serializers (PARITY=0 and PARITY=1) with shared random stimulus and
// compares every cycle against a queue-based model of the expected serial stream.
module tb_bit_serializer;

  localparam int WIDTH = 8;
  localparam int GAP   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_a, x_a, busy_a, done_a;
  logic             ready_b, x_b, busy_b, done_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Each entry is {x, busy, frame_done} for one future cycle.
  logic [2:0] qa[$];
  logic [2:0] qb[$];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(WIDTH), .GAP(GAP), .PARITY(0)) dut_a (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_a), .x(x_a), .busy(busy_a), .frame_done(done_a)
  );

  bit_serializer #(.WIDTH(WIDTH), .GAP(GAP), .PARITY(1)) dut_b (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_b), .x(x_b), .busy(busy_b), .frame_done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: an accepted word becomes L bit entries plus GAP idle-busy entries.
  always @(posedge clk) begin
    if (!reset) begin
      if (qa.size() != 0) void'(qa.pop_front());
      else if (valid_in) begin
        for (int k = 0; k < WIDTH; k++) qa.push_back({data_in[WIDTH-1-k], 1'b1, k == WIDTH-1});
        for (int g = 0; g < GAP; g++) qa.push_back(3'b010);
      end
      if (qb.size() != 0) void'(qb.pop_front());
      else if (valid_in) begin
        for (int k = 0; k < WIDTH; k++) qb.push_back({data_in[WIDTH-1-k], 1'b1, 1'b0});
        qb.push_back({^data_in, 1'b1, 1'b1});
        for (int g = 0; g < GAP; g++) qb.push_back(3'b010);
      end
    end
  end

  always @(posedge reset) begin
    qa.delete();
    qb.delete();
  end

  task automatic compare_all();
    logic [2:0] ea, eb;
    ea = (qa.size() != 0) ? qa[0] : 3'b000;
    eb = (qb.size() != 0) ? qb[0] : 3'b000;
    check("a_x",     32'(x_a),     32'(ea[2]));
    check("a_busy",  32'(busy_a),  32'(ea[1]));
    check("a_done",  32'(done_a),  32'(ea[0]));
    check("a_ready", 32'(ready_a), 32'(!reset && qa.size() == 0));
    check("b_x",     32'(x_b),     32'(eb[2]));
    check("b_busy",  32'(busy_b),  32'(eb[1]));
    check("b_done",  32'(done_b),  32'(eb[0]));
    check("b_ready", 32'(ready_b), 32'(!reset && qb.size() == 0));
  endtask

  task automatic cycle(input logic v, input logic [WIDTH-1:0] d);
    @(negedge clk);
    compare_all();
    valid_in = v;
    data_in  = d;
  endtask

  // Offer one word from idle, then capture the serial bits of both instances.
  task automatic directed(input logic [7:0] d, input logic [7:0] exp_a, input logic [8:0] exp_b);
    logic [7:0] got_a;
    logic [8:0] got_b;
    got_a = '0;
    got_b = '0;
    for (int i = 0; i < 14; i++) cycle(1'b0, 8'h00);
    cycle(1'b1, d);
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b0, 8'h00);
      if (k <= 8) got_a = {got_a[6:0], x_a};
      got_b = {got_b[7:0], x_b};
    end
    check("a_frame_bits", 32'(got_a), 32'(exp_a));
    check("b_frame_bits", 32'(got_b), 32'(exp_b));
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF);
    @(negedge clk);
    compare_all();
    reset    = 1'b0;
    valid_in = 1'b0;
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00);

    directed(8'hA5, 8'hA5, 9'h14A);
    directed(8'h07, 8'h07, 9'h00F);

    // Valid held high: back-to-back frames, data changing mid-frame.
    cycle(1'b1, 8'hA5);
    for (int i = 0; i < 11; i++) cycle(1'b1, 8'h3C);
    for (int i = 0; i < 30; i++) cycle(1'b1, 8'(($urandom % 2) ? 8'h00 : 8'hFF));

    for (int i = 0; i < 300; i++) cycle(($urandom % 4) != 0, 8'($urandom));

    // Reset in the middle of a frame.
    for (int i = 0; i < 14; i++) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'hA5);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00);
    @(negedge clk);
    compare_all();
    #2 reset = 1'b1;
    #1;
    check("rst_a_x",    32'(x_a),    32'd0);
    check("rst_a_busy", 32'(busy_a), 32'd0);
    check("rst_a_done", 32'(done_a), 32'd0);
    check("rst_b_x",    32'(x_b),    32'd0);
    check("rst_b_busy", 32'(busy_b), 32'd0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00);
    @(negedge clk);
    compare_all();
    reset = 1'b0;
    directed(8'hA5, 8'hA5, 9'h14A);

    for (int i = 0; i < 300; i++) cycle(($urandom % 3) != 0, 8'($urandom));
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
